udm_bus_arb2: RTL and testbench

- Two-master, one-slave arbiter for the UDM-style request/ack/resp bus.
- Lets the UDM debug master (m0) and a second on-chip master (m1, e.g. a Citadel command sequencer) share the CSR/testmem bus segment.
- Grants requests round-robin and forwards them to the slave.
- Tracks outstanding reads in an in-order ID FIFO so each read response returns to the master that issued it.

---
 rtl/udm_bus_arb2.sv | 159 +++++++++++++++
 tb/tb_udm_bus_arb2.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/udm_bus_arb2.sv
// rtl/udm_bus_arb2.sv - two-master round-robin arbiter for the UDM request/ack/resp bus
//
// Shares one request/ack/resp slave segment between master 0 (UDM debug
// master) and master 1 (on-chip sequencer). Requests are granted
// round-robin and forwarded combinationally. Accepted reads record the
// issuing master in an in-order ID FIFO so each response is routed back.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   m{0,1}_req_i/_we_i      master request and write enable
//   m{0,1}_addr_bi/_be_bi   master address and byte enables
//   m{0,1}_wdata_bi         master write data
//   m{0,1}_ack_o            master request accepted this cycle
//   m{0,1}_resp_o/_rdata_bo master read response valid and data
//   s_req_o .. s_wdata_bo   forwarded request of the granted master
//   s_ack_i                 slave accepted the forwarded request
//   s_resp_i, s_rdata_bi    slave read response valid and data
//   err_o                   sticky: response arrived with no read outstanding

module udm_bus_arb2 #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int OUTST_POW = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_bi,
    input  logic [DW/8-1:0]   m0_be_bi,
    input  logic [DW-1:0]     m0_wdata_bi,
    output logic              m0_ack_o,
    output logic              m0_resp_o,
    output logic [DW-1:0]     m0_rdata_bo,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_bi,
    input  logic [DW/8-1:0]   m1_be_bi,
    input  logic [DW-1:0]     m1_wdata_bi,
    output logic              m1_ack_o,
    output logic              m1_resp_o,
    output logic [DW-1:0]     m1_rdata_bo,

    output logic              s_req_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_addr_bo,
    output logic [DW/8-1:0]   s_be_bo,
    output logic [DW-1:0]     s_wdata_bo,
    input  logic              s_ack_i,
    input  logic              s_resp_i,
    input  logic [DW-1:0]     s_rdata_bi,

    output logic              err_o
);

    localparam int DEPTH = 1 << OUTST_POW;
    localparam logic [OUTST_POW:0] DEPTH_CNT = (OUTST_POW+1)'(DEPTH);

    // rr_last: master that won the most recent accepted transfer.
    logic                 rr_last;
    logic [DEPTH-1:0]     id_fifo;
    logic [OUTST_POW-1:0] wr_ptr;
    logic [OUTST_POW-1:0] rd_ptr;
    logic [OUTST_POW:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic elig0;
    logic elig1;
    logic gnt;
    logic accept;
    logic push;
    logic pop;
    logic head;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);

    // Reads are masked on the registered full flag, so a pop in the
    // same cycle does not let a new read through until the next cycle.
    assign elig0 = m0_req_i && (m0_we_i || !fifo_full);
    assign elig1 = m1_req_i && (m1_we_i || !fifo_full);

    always_comb begin
        gnt        = 1'b0;
        s_req_o    = elig0 || elig1;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;

        if (elig0 && elig1) begin
            gnt = ~rr_last;
        end else if (elig1) begin
            gnt = 1'b1;
        end

        if (s_req_o) begin
            if (gnt) begin
                s_we_o     = m1_we_i;
                s_addr_bo  = m1_addr_bi;
                s_be_bo    = m1_be_bi;
                s_wdata_bo = m1_wdata_bi;
            end else begin
                s_we_o     = m0_we_i;
                s_addr_bo  = m0_addr_bi;
                s_be_bo    = m0_be_bi;
                s_wdata_bo = m0_wdata_bi;
            end
        end
    end

    assign accept   = s_req_o && s_ack_i;
    assign push     = accept && !s_we_o;
    assign m0_ack_o = accept && !gnt;
    assign m1_ack_o = accept && gnt;

    // A response only pops when a read was already outstanding at the
    // start of the cycle; otherwise it is dropped and flagged.
    assign head        = id_fifo[rd_ptr];
    assign pop         = s_resp_i && !fifo_empty;
    assign m0_resp_o   = pop && !head;
    assign m1_resp_o   = pop && head;
    assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
    assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_last <= 1'b1;
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_o   <= 1'b0;
        end else begin
            if (accept) begin
                rr_last <= gnt;
            end
            if (push) begin
                id_fifo[wr_ptr] <= gnt;
                wr_ptr          <= wr_ptr + OUTST_POW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + OUTST_POW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (OUTST_POW+1)'(1);
                2'b01:   count <= count - (OUTST_POW+1)'(1);
                default: count <= count;
            endcase
            if (s_resp_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_udm_bus_arb2.sv
// tb/tb_udm_bus_arb2.sv - directed self-checking bench for udm_bus_arb2

module tb_udm_bus_arb2;

    logic        clk_i;
    logic        rst_i;
    logic        m0_req_i, m0_we_i;
    logic [31:0] m0_addr_bi, m0_wdata_bi;
    logic [3:0]  m0_be_bi;
    logic        m0_ack_o, m0_resp_o;
    logic [31:0] m0_rdata_bo;
    logic        m1_req_i, m1_we_i;
    logic [31:0] m1_addr_bi, m1_wdata_bi;
    logic [3:0]  m1_be_bi;
    logic        m1_ack_o, m1_resp_o;
    logic [31:0] m1_rdata_bo;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_bo, s_wdata_bo;
    logic [3:0]  s_be_bo;
    logic        s_ack_i, s_resp_i;
    logic [31:0] s_rdata_bi;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;
    int n0;
    int n1;

    udm_bus_arb2 #(.AW(32), .DW(32), .OUTST_POW(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_bi  (m0_addr_bi),
        .m0_be_bi    (m0_be_bi),
        .m0_wdata_bi (m0_wdata_bi),
        .m0_ack_o    (m0_ack_o),
        .m0_resp_o   (m0_resp_o),
        .m0_rdata_bo (m0_rdata_bo),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_bi  (m1_addr_bi),
        .m1_be_bi    (m1_be_bi),
        .m1_wdata_bi (m1_wdata_bi),
        .m1_ack_o    (m1_ack_o),
        .m1_resp_o   (m1_resp_o),
        .m1_rdata_bo (m1_rdata_bo),
        .s_req_o     (s_req_o),
        .s_we_o      (s_we_o),
        .s_addr_bo   (s_addr_bo),
        .s_be_bo     (s_be_bo),
        .s_wdata_bo  (s_wdata_bo),
        .s_ack_i     (s_ack_i),
        .s_resp_i    (s_resp_i),
        .s_rdata_bi  (s_rdata_bi),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        m0_req_i = req; m0_we_i = we; m0_addr_bi = addr; m0_wdata_bi = wd; m0_be_bi = 4'hF;
    endtask

    task automatic drv_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        m1_req_i = req; m1_we_i = we; m1_addr_bi = addr; m1_wdata_bi = wd; m1_be_bi = 4'hF;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_i = 1'b0;
        drv_m0(0, 0, 0, 0);
        drv_m1(0, 0, 0, 0);
        s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;

        // reset state
        #3;
        chk("rst_err", err_o, 0);
        chk("rst_sreq", s_req_o, 0);
        chk("rst_m0ack", m0_ack_o, 0);
        @(negedge clk_i); rst_i = 1'b1;

        // read ordering
        drv_m0(1, 0, 32'h100, 0); drv_m1(1, 0, 32'h200, 0); s_ack_i = 1; #1;
        chk("ord_m0ack", m0_ack_o, 1);
        chk("ord_m1ack0", m1_ack_o, 0);
        chk("ord_addr_a", s_addr_bo, 32'h100);
        chk("ord_we", s_we_o, 0);
        @(negedge clk_i); m0_req_i = 0; #1;
        chk("ord_m1ack", m1_ack_o, 1);
        chk("ord_addr_b", s_addr_bo, 32'h200);
        @(negedge clk_i); m1_req_i = 0; s_ack_i = 0; s_resp_i = 1; s_rdata_bi = 32'h11111111; #1;
        chk("ord_r0_resp", m0_resp_o, 1);
        chk("ord_r0_data", m0_rdata_bo, 32'h11111111);
        chk("ord_r0_m1resp", m1_resp_o, 0);
        @(negedge clk_i); s_rdata_bi = 32'h22222222; #1;
        chk("ord_r1_resp", m1_resp_o, 1);
        chk("ord_r1_data", m1_rdata_bo, 32'h22222222);
        chk("ord_r1_m0resp", m0_resp_o, 0);
        chk("ord_r1_m0data", m0_rdata_bo, 0);
        @(negedge clk_i); s_resp_i = 0; #1;
        chk("ord_err", err_o, 0);

        // fairness from reset
        rst_i = 0; #1; rst_i = 1;
        drv_m0(1, 1, 32'h10, 32'hA0A0A0A0); drv_m1(1, 1, 32'h20, 32'hB0B0B0B0); s_ack_i = 1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk($sformatf("fair_m0ack_%0d", i), m0_ack_o, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("fair_wd_%0d", i), s_wdata_bo, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB0B0B0B0);
            n0 += int'(m0_ack_o);
            n1 += int'(m1_ack_o);
        end
        @(negedge clk_i); m0_req_i = 0; m1_req_i = 0; #1;
        chk("fair_n0", n0, 4);
        chk("fair_n1", n1, 4);

        // FIFO full
        drv_m1(1, 0, 32'h300, 0); s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk($sformatf("full_fill_%0d", i), m1_ack_o, 1);
        end
        @(negedge clk_i); drv_m0(1, 1, 32'h310, 32'hC); #1;
        chk("full_m0wr_ack", m0_ack_o, 1);
        chk("full_m1_blocked", m1_ack_o, 0);
        chk("full_we", s_we_o, 1);
        @(negedge clk_i); m0_req_i = 0; s_resp_i = 1; s_rdata_bi = 32'h33333333; #1;
        chk("full_pop_sreq", s_req_o, 0);
        chk("full_pop_m1ack", m1_ack_o, 0);
        chk("full_pop_resp", m1_resp_o, 1);
        chk("full_pop_data", m1_rdata_bo, 32'h33333333);
        @(negedge clk_i); s_resp_i = 0; #1;
        chk("full_fifth_ack", m1_ack_o, 1);
        @(negedge clk_i); m1_req_i = 0; s_ack_i = 0; s_resp_i = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk($sformatf("full_drain_%0d", i), m1_resp_o, 1);
        end

        // backpressure
        @(negedge clk_i); s_resp_i = 0; drv_m0(1, 0, 32'h400, 0); s_ack_i = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk($sformatf("bp_noack_%0d", i), m0_ack_o, 0);
            chk($sformatf("bp_sreq_%0d", i), s_req_o, 1);
        end
        @(negedge clk_i); s_ack_i = 1; #1;
        chk("bp_ack", m0_ack_o, 1);
        @(negedge clk_i); s_ack_i = 0; drv_m0(1, 1, 32'h410, 0); drv_m1(1, 1, 32'h500, 0); #1;
        chk("bp_rr_m1", s_addr_bo, 32'h500);
        @(negedge clk_i); m0_req_i = 0; m1_req_i = 0; s_resp_i = 1; s_rdata_bi = 32'h44444444; #1;
        chk("bp_resp", m0_resp_o, 1);
        chk("bp_rdata", m0_rdata_bo, 32'h44444444);

        // spurious response (single push means FIFO is now empty)
        @(negedge clk_i); #1;
        chk("sp_m0resp", m0_resp_o, 0);
        chk("sp_m1resp", m1_resp_o, 0);
        chk("sp_err_pre", err_o, 0);
        @(negedge clk_i); s_resp_i = 0; #1;
        chk("sp_err_set", err_o, 1);
        @(negedge clk_i); #1;
        chk("sp_err_held", err_o, 1);
        rst_i = 0; #1;
        chk("sp_err_clr", err_o, 0);
        @(negedge clk_i); rst_i = 1;

        // async reset with two reads outstanding
        drv_m1(1, 0, 32'h600, 0); s_ack_i = 1; #1;
        chk("ar_m1ack", m1_ack_o, 1);
        @(negedge clk_i); m1_req_i = 0; drv_m0(1, 0, 32'h700, 0); #1;
        chk("ar_m0ack", m0_ack_o, 1);
        @(negedge clk_i); m0_req_i = 0; s_ack_i = 0; s_resp_i = 1; s_rdata_bi = 32'h55555555; #1;
        chk("ar_head_m1", m1_resp_o, 1);
        #1; rst_i = 0; #1;
        chk("ar_m1resp_clr", m1_resp_o, 0);
        chk("ar_m0resp_clr", m0_resp_o, 0);
        s_resp_i = 0;
        @(negedge clk_i); rst_i = 1; s_resp_i = 1;
        @(negedge clk_i); s_resp_i = 0; #1;
        chk("ar_err_late", err_o, 1);
        rst_i = 0; #1; rst_i = 1;
        drv_m0(1, 0, 32'h800, 0); drv_m1(1, 0, 32'h900, 0); s_ack_i = 1; #1;
        chk("ar_grant_m0", m0_ack_o, 1);
        chk("ar_grant_m1", m1_ack_o, 0);
        chk("ar_addr", s_addr_bo, 32'h800);
        @(negedge clk_i); m0_req_i = 0; m1_req_i = 0; s_ack_i = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
